// File: rtl/alu_pkg.sv
// Shared types for the ALU result stage: payload struct and occupancy states.
package alu_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned RD_W   = 5;

    typedef struct packed {
        logic [DATA_W-1:0] res;
        logic              zero;
        logic [RD_W-1:0]   rd;
        logic              we;
    } alu_res_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } stage_state_t;

endpackage

// File: rtl/alu_perf_ctr.sv
// 32-bit wrapping event counter with increment enable and synchronous reset.
module alu_perf_ctr (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc_i,
    output logic [31:0] count_o
);

    logic [31:0] count_q;
    logic [31:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i) begin
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/alu_result_stage.sv
// Registered ALU output stage with a 2-entry skid buffer and synchronous flush.
// Define ALU_RES_PERF_EN to add the perf_xfers / perf_zeros transfer counters.
module alu_result_stage #(
    parameter int unsigned DATA_W = alu_pkg::DATA_W,
    parameter int unsigned RD_W   = alu_pkg::RD_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_res,
    input  logic              in_zero,
    input  logic [RD_W-1:0]   in_rd,
    input  logic              in_we,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_res,
    output logic              out_zero,
    output logic [RD_W-1:0]   out_rd,
    output logic              out_we
`ifdef ALU_RES_PERF_EN
    ,
    output logic [31:0]       perf_xfers,
    output logic [31:0]       perf_zeros
`endif
);

    import alu_pkg::*;

    stage_state_t state_q, state_d;
    alu_res_t     main_q, main_d;
    alu_res_t     skid_q, skid_d;
    logic         in_ready_q, in_ready_d;
    alu_res_t     in_entry;
    logic         in_xfer;

    assign in_entry = '{res: in_res, zero: in_zero, rd: in_rd, we: in_we};
    assign in_xfer  = in_valid & in_ready_q;

    always_comb begin
        state_d    = state_q;
        main_d     = main_q;
        skid_d     = skid_q;
        in_ready_d = in_ready_q;
        if (flush) begin
            state_d    = EMPTY;
            main_d     = '0;
            skid_d     = '0;
            in_ready_d = 1'b1;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        main_d  = in_entry;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (in_xfer && out_ready) begin
                        main_d = in_entry;
                    end else if (in_xfer) begin
                        skid_d     = in_entry;
                        state_d    = TWO;
                        in_ready_d = 1'b0;
                    end else if (out_ready) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (out_ready) begin
                        main_d     = skid_q;
                        skid_d     = '0;
                        state_d    = ONE;
                        in_ready_d = 1'b1;
                    end
                end
                default: begin
                    state_d    = EMPTY;
                    in_ready_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != EMPTY);
    assign out_res   = main_q.res;
    assign out_zero  = main_q.zero;
    assign out_rd    = main_q.rd;
    // Main entry keeps stale payload after draining, so we must be qualified.
    assign out_we    = main_q.we & out_valid;

`ifdef ALU_RES_PERF_EN
    logic out_xfer;
    assign out_xfer = out_valid & out_ready;

    alu_perf_ctr u_ctr_xfers (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (out_xfer),
        .count_o (perf_xfers)
    );

    alu_perf_ctr u_ctr_zeros (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (out_xfer & main_q.zero),
        .count_o (perf_zeros)
    );
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed self-checking bench for alu_result_stage; perf counters checked when ALU_RES_PERF_EN is defined.
module tb_alu_result_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_res;
    logic        in_zero;
    logic [4:0]  in_rd;
    logic        in_we;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_res;
    logic        out_zero;
    logic [4:0]  out_rd;
    logic        out_we;
`ifdef ALU_RES_PERF_EN
    logic [31:0] perf_xfers;
    logic [31:0] perf_zeros;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_result_stage #(
        .DATA_W (32),
        .RD_W   (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_res    (in_res),
        .in_zero   (in_zero),
        .in_rd     (in_rd),
        .in_we     (in_we),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_zero  (out_zero),
        .out_rd    (out_rd),
        .out_we    (out_we)
`ifdef ALU_RES_PERF_EN
        ,
        .perf_xfers(perf_xfers),
        .perf_zeros(perf_zeros)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        in_valid = 1'b1; in_res = 32'hDEAD_BEEF; in_zero = 1'b1; in_rd = 5'd31; in_we = 1'b1;
        tick();
        tick();
        rst = 1'b0; in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
        n_cmp++; if (out_res !== 32'h0) begin n_err++; $display("FAIL reset_out_res: got %h want 0", out_res); end
        n_cmp++; if (out_zero !== 1'b0) begin n_err++; $display("FAIL reset_out_zero: got %0b want 0", out_zero); end
        n_cmp++; if (out_rd !== 5'd0) begin n_err++; $display("FAIL reset_out_rd: got %0d want 0", out_rd); end
        n_cmp++; if (out_we !== 1'b0) begin n_err++; $display("FAIL reset_out_we: got %0b want 0", out_we); end
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        in_valid = 1'b1; in_res = 32'h0000_0005; in_zero = 1'b0; in_rd = 5'd3; in_we = 1'b1;
        tick();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %0b want 1", out_valid); end
        n_cmp++; if (out_res !== 32'h5) begin n_err++; $display("FAIL single_res: got %h want 5", out_res); end
        n_cmp++; if (out_zero !== 1'b0) begin n_err++; $display("FAIL single_zero: got %0b want 0", out_zero); end
        n_cmp++; if (out_rd !== 5'd3) begin n_err++; $display("FAIL single_rd: got %0d want 3", out_rd); end
        n_cmp++; if (out_we !== 1'b1) begin n_err++; $display("FAIL single_we: got %0b want 1", out_we); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_drain_valid: got %0b want 0", out_valid); end
        n_cmp++; if (out_we !== 1'b0) begin n_err++; $display("FAIL single_drain_we_gated: got %0b want 0", out_we); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1; in_res = 32'h11; in_zero = 1'b0; in_rd = 5'd1; in_we = 1'b1;
        tick();
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_one: got %0b want 1", in_ready); end
        in_res = 32'h22; in_rd = 5'd2;
        tick();
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_two: got %0b want 0", in_ready); end
        n_cmp++; if (out_res !== 32'h11) begin n_err++; $display("FAIL bp_head_11: got %h want 11", out_res); end
        in_res = 32'h33; in_rd = 5'd3;
        tick();
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_held_off: got %0b want 0", in_ready); end
        n_cmp++; if (out_res !== 32'h11 || out_rd !== 5'd1 || out_valid !== 1'b1) begin
            n_err++; $display("FAIL bp_stall_stable: got res=%h rd=%0d v=%0b want res=11 rd=1 v=1", out_res, out_rd, out_valid); end
        out_ready = 1'b1;
        tick();
        n_cmp++; if (out_valid !== 1'b1 || out_res !== 32'h22) begin
            n_err++; $display("FAIL bp_second: got v=%0b res=%h want v=1 res=22", out_valid, out_res); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_back: got %0b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1 || out_res !== 32'h33 || out_rd !== 5'd3) begin
            n_err++; $display("FAIL bp_third: got v=%0b res=%h rd=%0d want v=1 res=33 rd=3", out_valid, out_res, out_rd); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drained: got %0b want 0", out_valid); end
    endtask

    task automatic test_streaming();
        logic [31:0] exp_res;
        logic        exp_zero;
        logic [4:0]  exp_rd;
        logic        exp_we;
        int          seen;
        seen = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1;
            in_res   = 32'h100 + 32'(i * 3);
            in_zero  = (i % 5 == 0);
            in_rd    = 5'(i % 32);
            in_we    = i[0];
            n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stream_ready[%0d]: got %0b want 1", i, in_ready); end
            tick();
            exp_res  = 32'h100 + 32'(i * 3);
            exp_zero = (i % 5 == 0);
            exp_rd   = 5'(i % 32);
            exp_we   = i[0];
            if (out_valid === 1'b1) seen++;
            n_cmp++; if (out_valid !== 1'b1 || out_res !== exp_res || out_zero !== exp_zero || out_rd !== exp_rd || out_we !== exp_we) begin
                n_err++;
                $display("FAIL stream_out[%0d]: got v=%0b res=%h z=%0b rd=%0d we=%0b want v=1 res=%h z=%0b rd=%0d we=%0b",
                         i, out_valid, out_res, out_zero, out_rd, out_we, exp_res, exp_zero, exp_rd, exp_we);
            end
        end
        in_valid = 1'b0;
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stream_drained: got %0b want 0", out_valid); end
        n_cmp++; if (seen != 100) begin n_err++; $display("FAIL stream_count: got %0d want 100", seen); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1; in_res = 32'hA1; in_zero = 1'b0; in_rd = 5'd7; in_we = 1'b1;
        tick();
        in_res = 32'hA2;
        tick();
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL flush_setup_two: got %0b want 0", in_ready); end
        flush = 1'b1; in_res = 32'h44;
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %0b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL flush_ready: got %0b want 1", in_ready); end
        n_cmp++; if (out_res !== 32'h0 || out_rd !== 5'd0) begin
            n_err++; $display("FAIL flush_zeroed: got res=%h rd=%0d want 0 0", out_res, out_rd); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_no_emit[%0d]: got %0b want 0", i, out_valid); end
        end
        // Flush from EMPTY with a ready-to-accept input: it must be dropped.
        flush = 1'b1; in_valid = 1'b1; in_res = 32'h55;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_drop_input: got %0b want 0", out_valid); end
    endtask

    task automatic test_gating();
        out_ready = 1'b1;
        in_valid = 1'b0; in_we = 1'b1; in_res = 32'h0; in_zero = 1'b1;
        tick();
        n_cmp++; if (out_we !== 1'b0 || out_valid !== 1'b0) begin
            n_err++; $display("FAIL gating_we: got we=%0b v=%0b want 0 0", out_we, out_valid); end
`ifdef ALU_RES_PERF_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if (perf_xfers !== 32'd0 || perf_zeros !== 32'd0) begin
            n_err++; $display("FAIL perf_reset: got x=%0d z=%0d want 0 0", perf_xfers, perf_zeros); end
        in_valid = 1'b1; in_res = 32'h0; in_zero = 1'b1; in_rd = 5'd1; in_we = 1'b1;
        tick();
        in_res = 32'h7; in_zero = 1'b0;
        tick();
        in_res = 32'h0; in_zero = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_cmp++; if (perf_xfers !== 32'd3) begin n_err++; $display("FAIL perf_xfers: got %0d want 3", perf_xfers); end
        n_cmp++; if (perf_zeros !== 32'd2) begin n_err++; $display("FAIL perf_zeros: got %0d want 2", perf_zeros); end
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_streaming();
        test_flush();
        test_gating();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Registered output stage directly downstream of the ALU.
- Captures each ALU result, zero flag, destination register and write-enable, and presents them to the memory/writeback stage over a valid/ready handshake.
- A 2-entry skid buffer gives full throughput with a registered in_ready.
- Synchronous flush discards wrong-path results after a branch.

Parameters:
- DATA_W, 32, width of ALU result
- RD_W, 5, width of destination register index

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous active-high reset
- in_valid  input  1  ALU result valid this cycle
- in_ready  output  1  stage can accept; registered
- in_res  input  DATA_W  ALU result
- in_zero  input  1  ALU zero flag
- in_rd  input  RD_W  destination register index
- in_we  input  1  register write enable
- flush  input  1  discard all held and incoming entries
- out_valid  output  1  output entry valid
- out_ready  input  1  downstream accepts
- out_res  output  DATA_W  held result
- out_zero  output  1  held zero flag
- out_rd  output  RD_W  held destination index
- out_we  output  1  held write enable, gated by out_valid

Behaviour:
- Clocking and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: in_ready=1, out_valid=0, out_res=0, out_zero=0, out_rd=0, out_we=0. State=EMPTY. Skid entry cleared.
- Transfers: input transfer when in_valid & in_ready; output transfer when out_valid & out_ready.
- Latency and throughput: 1 cycle from input transfer to out_valid; sustained 1 transfer/cycle while out_ready=1.
- States: EMPTY (no entry), ONE (main entry only), TWO (main and skid full).
- EMPTY: input transfer loads main -> ONE.
- ONE, input transfer & out_ready: main replaced by new entry, stay ONE.
- ONE, input transfer & !out_ready: new entry into skid -> TWO; in_ready=0 from next cycle.
- ONE, no input & out_ready: -> EMPTY.
- ONE, otherwise: hold.
- TWO: in_ready=0, inputs ignored. out_ready moves skid to main -> ONE; in_ready=1 from next cycle.
- Ordering: strict FIFO, never reorders or duplicates.
- Stall: while out_valid & !out_ready, all out_* stay bit-stable.
- out_we: combinationally ANDed with out_valid, so it is never 1 while out_valid=0.
- Flush: priority below rst, above everything else. Next state is EMPTY, all valids cleared, in_ready=1, data registers zeroed. An input presented in the flush cycle is not accepted. An output transfer in the flush cycle counts as completed.
- Data handling: no arithmetic on payload; in_zero is passed through, not recomputed.
- Reset mid-operation: any state -> reset values in the next cycle; entries are lost.

Optional Feature:
- Macro: ALU_RES_PERF_EN.
- With it defined: adds outputs perf_xfers[31:0] (count of output transfers) and perf_zeros[31:0] (count of output transfers with out_zero=1).
  - Both counters reset to 0 on rst; flush does not clear them.
  - Both wrap from 0xFFFFFFFF to 0.
- Without it: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package alu_pkg holds:
  - DATA_W and RD_W constants
  - struct alu_res_t {res, zero, rd, we}
  - enum stage_state_t {EMPTY, ONE, TWO}
- Sub-module alu_perf_ctr: 32-bit wrapping counter with increment enable, instantiated twice under ALU_RES_PERF_EN.

Test Plan:
- Reset: hold rst 2 cycles with in_valid=1 -> out_valid=0, in_ready=1 and all out_* = 0 on release.
- Single entry: in_res=0x0000_0005, in_zero=0, in_rd=3, in_we=1 with out_ready=1 -> next cycle out_valid=1 and the same fields; following cycle out_valid=0.
- Back-pressure: out_ready=0, feed 0x11 then 0x22 on consecutive cycles -> in_ready=0 after the second. A third value 0x33 is held off. Raising out_ready yields 0x11, 0x22, 0x33 in order with no gaps.
- Streaming: 100 back-to-back inputs with out_ready=1 -> 100 outputs, one per cycle, 1-cycle latency, in_ready constantly 1.
- Flush: in state TWO assert flush with in_valid=1 and in_res=0x44 -> next cycle out_valid=0, in_ready=1; 0x44 is never emitted.
- Gating: in_we=1, in_res=0 while out_valid=0 -> out_we=0. Under ALU_RES_PERF_EN, 3 transfers of which 2 are zero results -> perf_xfers=3, perf_zeros=2.
